i2s_tx_scheduler: RTL and testbench
===================================

// Module: i2s_tx_scheduler
// PURPOSE
//  Controller in front of the I2S master: generates its clk_en/mclk_en/sclk_en strobes and sequences start/stop.
//  Arbitrates two stereo sample sources (e.g. DMA playback, tone generator) into the master's sample interface.
//  Keeps a one-sample holding register and inserts silence on underrun, counting each underrun event.
// PARAMETERS
//  MCLK_DIV    4   clk cycles between mclk_en strobes (= mclk half-period); >=2
//  SCLK_DIV    16  clk cycles between sclk_en strobes (= sclk half-period); >=2, integer multiple of MCLK_DIV
//  REFILL_WIN  64  clk cycles after i2s_ready during which a source may supply the next sample
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset, synchronous, active-high
//  cfg_enable    in   1   1 = play; 0 = stop after current frame
//  cfg_prio      in   1   0: src0 has priority; 1: src1 has priority
//  src0_data     in   48  {left[23:0], right[23:0]}
//  src0_valid    in   1   src0 sample available
//  src0_ready    out  1   src0 sample taken this cycle
//  src1_data     in   48  as src0
//  src1_valid    in   1   as src0
//  src1_ready    out  1   as src0
//  i2s_clk_en    out  1   to master clk_en
//  i2s_mclk_en   out  1   to master mclk_en
//  i2s_sclk_en   out  1   to master sclk_en
//  i2s_data      out  48  to master fifo_data
//  i2s_valid     out  1   to master fifo_valid
//  i2s_ready     in   1   master fifo_ready: 1-cycle pulse, sample consumed
//  busy          out  1   state != IDLE
//  active_src    out  1   source of the sample most recently loaded into the holding register
//  underrun_cnt  out  16  saturating count of silence insertions
//  underrun_clr  in   1   synchronous clear of underrun_cnt
// BEHAVIOUR
//  Reset: state IDLE; all strobes, i2s_valid, srcN_ready 0; i2s_data 0; active_src 0; underrun_cnt 0.
//  FSM IDLE -> PRIME when cfg_enable=1. PRIME: enable off, refill (below) until hold_valid -> RUN.
//   RUN: i2s_clk_en=1, strobe counters run. cfg_enable=0 -> DRAIN.
//   DRAIN: no refill. After next i2s_ready, hold_valid=0; count 128 sclk_en strobes (one 64-sclk frame) -> IDLE.
//   cfg_enable back to 1 in DRAIN is ignored until IDLE is reached.
//  Strobes: mclk/sclk counters cleared on entry to RUN (phase aligned). Each strobe is a 1-cycle pulse
//   every MCLK_DIV / SCLK_DIV cycles. First pulse is MCLK_DIV / SCLK_DIV cycles after RUN entry. Both 0 outside RUN/DRAIN.
//  Holding reg: i2s_data=hold_data; i2s_valid=hold_valid. i2s_ready with hold_valid=1 -> hold_valid=0 next cycle,
//   refill window opens (counter = REFILL_WIN).
//  Refill (PRIME, or RUN window open): grant = priority source if valid, else the other if valid.
//   srcN_ready = refill_active & grant==N (combinational). Data loaded and hold_valid=1 same edge.
//   active_src updated on that edge. Arbitration is per sample, no mid-sample switching.
//  Underrun: window expires with no grant -> load 48'h0 with hold_valid=1, underrun_cnt+1 (saturates at 16'hFFFF).
//   PRIME never underruns; it waits.
//  underrun_clr with a simultaneous increment -> result 0. i2s_ready while hold_valid=0 is ignored.
//  Reset mid-operation: all state to reset values next edge; the master must be reset alongside.
// STRUCTURE
//  Shared audio_pkg: SAMPLE_W=48, CH_W=24, FRAME_SCLKS=64, SILENCE=48'h0, FSM state encoding localparams.
//  One sub-module: i2s_strobe_gen (MCLK_DIV/SCLK_DIV counters, enable/clear inputs, two pulse outputs).
//  Top: FSM, holding register, 2-way arbiter, refill window counter, underrun counter.
// TESTING
//  1 Reset, cfg_enable=1, src0 holds 48'hAAAAAA555555 -> PRIME takes it. i2s_valid=1.
//    First sclk_en 16 cycles after RUN entry, mclk_en every 4 cycles.
//  2 Both sources valid, cfg_prio=0 -> src0_ready only. cfg_prio=1 -> src1_ready only. active_src follows the grant.
//  3 src0 idle, src1 valid, cfg_prio=0 -> src1 granted (fallback), active_src=1.
//  4 No source valid for 64 cycles after i2s_ready -> i2s_data=0, i2s_valid=1, underrun_cnt 0->1.
//    Preload 16'hFFFF -> stays 16'hFFFF.
//  5 cfg_enable=0 mid-frame -> no srcN_ready. After next i2s_ready plus 128 sclk_en strobes: busy=0, all strobes 0.
//  6 rst pulsed during RUN -> next cycle: IDLE, strobes 0, i2s_valid 0, underrun_cnt 0. Also underrun_clr with a simultaneous underrun -> 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: sample layout, frame geometry, silence word and
// the scheduler FSM state encoding.
package audio_pkg;

    localparam int SAMPLE_W      = 48;
    localparam int CH_W          = 24;
    localparam int FRAME_SCLKS   = 64;
    localparam int DRAIN_STROBES = 2 * FRAME_SCLKS;

    localparam logic [SAMPLE_W-1:0] SILENCE = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PRIME = ST_PRIME,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] left;
        logic [CH_W-1:0] right;
    } sample_t;

endpackage

// File: rtl/i2s_strobe_gen.sv
// mclk/sclk enable strobe generator: one-cycle pulses every MCLK_DIV / SCLK_DIV
// cycles while en=1. Ports: clk, rst, en, clr (phase reset) -> mclk_en, sclk_en.
module i2s_strobe_gen #(
    parameter int MCLK_DIV = 4,
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic mclk_en,
    output logic sclk_en
);

    localparam int MW = $clog2(MCLK_DIV);
    localparam int SW = $clog2(SCLK_DIV);

    logic [MW-1:0] mcnt;
    logic [SW-1:0] scnt;
    logic          mpulse;
    logic          spulse;
    logic          mwrap;
    logic          swrap;

    assign mwrap = (mcnt == MW'(MCLK_DIV - 1));
    assign swrap = (scnt == SW'(SCLK_DIV - 1));

    // Pulses are registered, so the first one lands DIV cycles after clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mcnt   <= '0;
            scnt   <= '0;
            mpulse <= 1'b0;
            spulse <= 1'b0;
        end else if (en) begin
            mpulse <= mwrap;
            spulse <= swrap;
            mcnt   <= mwrap ? '0 : mcnt + 1'b1;
            scnt   <= swrap ? '0 : scnt + 1'b1;
        end
    end

    assign mclk_en = mpulse & en;
    assign sclk_en = spulse & en;

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S master front end: strobes, start/stop sequencing, 2-source arbitration,
// one-sample holding register with silence on underrun.
// Ports: src0/src1 sample streams in, i2s_* master interface out, busy,
// active_src, underrun_cnt/underrun_clr status.
module i2s_tx_scheduler
    import audio_pkg::*;
#(
    parameter int MCLK_DIV   = 4,
    parameter int SCLK_DIV   = 16,
    parameter int REFILL_WIN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic                cfg_prio,
    input  logic [SAMPLE_W-1:0] src0_data,
    input  logic                src0_valid,
    output logic                src0_ready,
    input  logic [SAMPLE_W-1:0] src1_data,
    input  logic                src1_valid,
    output logic                src1_ready,
    output logic                i2s_clk_en,
    output logic                i2s_mclk_en,
    output logic                i2s_sclk_en,
    output logic [SAMPLE_W-1:0] i2s_data,
    output logic                i2s_valid,
    input  logic                i2s_ready,
    output logic                busy,
    output logic                active_src,
    output logic [15:0]         underrun_cnt,
    input  logic                underrun_clr
);

    localparam int WIN_W = $clog2(REFILL_WIN + 1);
    localparam int DR_W  = $clog2(DRAIN_STROBES);

    state_t        state;
    state_t        nxt;
    sample_t       hold_data;
    logic          hold_valid;
    logic [WIN_W-1:0] win_cnt;
    logic [DR_W-1:0]  drain_cnt;

    logic refill;
    logic run_clks;
    logic run_entry;
    logic grant;
    logic grant_ok;
    logic take;
    logic consume;
    logic underrun_evt;
    logic drain_cnt_en;
    logic drain_done;

    // grant selects src1 when set; only meaningful with grant_ok
    assign grant_ok = src0_valid | src1_valid;
    assign grant    = cfg_prio ? src1_valid : ~src0_valid;
    assign take     = refill & grant_ok;
    assign consume  = i2s_ready & hold_valid;

    assign src0_ready = take & ~grant;
    assign src1_ready = take & grant;

    assign underrun_evt = (state == RUN) & ~hold_valid & ~grant_ok
                        & (win_cnt == WIN_W'(1));

    // Frame countdown starts once the last sample has left the hold register.
    assign drain_cnt_en = (state == DRAIN) & ~hold_valid;
    assign drain_done   = drain_cnt_en & i2s_sclk_en
                        & (drain_cnt == DR_W'(DRAIN_STROBES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt      = state;
        refill   = 1'b0;
        run_clks = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_enable) nxt = PRIME;
            end
            PRIME: begin
                refill = ~hold_valid;
                if (hold_valid) nxt = RUN;
            end
            RUN: begin
                run_clks = 1'b1;
                refill   = ~hold_valid;
                if (!cfg_enable) nxt = DRAIN;
            end
            DRAIN: begin
                run_clks = 1'b1;
                if (drain_done) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign run_entry = (state == PRIME) & (nxt == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= SILENCE;
            hold_valid <= 1'b0;
            active_src <= 1'b0;
        end else if (take) begin
            hold_data  <= grant ? src1_data : src0_data;
            hold_valid <= 1'b1;
            active_src <= grant;
        end else if (underrun_evt) begin
            hold_data  <= SILENCE;
            hold_valid <= 1'b1;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            win_cnt <= '0;
        else if (consume)
            win_cnt <= WIN_W'(REFILL_WIN);
        else if (state == RUN && !hold_valid && win_cnt != '0)
            win_cnt <= win_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || !drain_cnt_en)
            drain_cnt <= '0;
        else if (i2s_sclk_en)
            drain_cnt <= drain_cnt + 1'b1;
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || underrun_clr)
            underrun_cnt <= '0;
        else if (underrun_evt && underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + 1'b1;
    end

    i2s_strobe_gen #(
        .MCLK_DIV (MCLK_DIV),
        .SCLK_DIV (SCLK_DIV)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .en      (run_clks),
        .clr     (run_entry),
        .mclk_en (i2s_mclk_en),
        .sclk_en (i2s_sclk_en)
    );

    assign i2s_clk_en = run_clks;
    assign i2s_data   = hold_data;
    assign i2s_valid  = hold_valid;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Scoreboard bench for i2s_tx_scheduler: expected samples are queued by the
// stimulus and popped by a monitor on every master handshake.
module tb_i2s_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic        cfg_prio;
    logic [47:0] src0_data;
    logic        src0_valid;
    logic        src0_ready;
    logic [47:0] src1_data;
    logic        src1_valid;
    logic        src1_ready;
    logic        i2s_clk_en;
    logic        i2s_mclk_en;
    logic        i2s_sclk_en;
    logic [47:0] i2s_data;
    logic        i2s_valid;
    logic        i2s_ready;
    logic        busy;
    logic        active_src;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    int checks = 0;
    int errors = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp_v;

    i2s_tx_scheduler #(
        .MCLK_DIV   (4),
        .SCLK_DIV   (16),
        .REFILL_WIN (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enable   (cfg_enable),
        .cfg_prio     (cfg_prio),
        .src0_data    (src0_data),
        .src0_valid   (src0_valid),
        .src0_ready   (src0_ready),
        .src1_data    (src1_data),
        .src1_valid   (src1_valid),
        .src1_ready   (src1_ready),
        .i2s_clk_en   (i2s_clk_en),
        .i2s_mclk_en  (i2s_mclk_en),
        .i2s_sclk_en  (i2s_sclk_en),
        .i2s_data     (i2s_data),
        .i2s_valid    (i2s_valid),
        .i2s_ready    (i2s_ready),
        .busy         (busy),
        .active_src   (active_src),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted sample must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && i2s_valid && i2s_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_unexpected: got %h expected none",
                         i2s_data);
            end else begin
                exp_v = exp_q.pop_front();
                chk("sample_data", {16'h0, i2s_data}, {16'h0, exp_v});
            end
        end
    end

    task automatic pulse_ready();
        i2s_ready = 1'b1;
        step(1);
        i2s_ready = 1'b0;
    endtask

    task automatic wait_run(output bit ok, output bit r0, output bit r1);
        ok = 1'b0;
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i2s_clk_en) begin
                ok = 1'b1;
                break;
            end
            r0 |= src0_ready;
            r1 |= src1_ready;
            step(1);
        end
    endtask

    // Called in the first RUN cycle; records cycles 0..16.
    task automatic check_strobes();
        logic [16:0] m, s, em, es;
        for (int k = 0; k <= 16; k++) begin
            m[k]  = i2s_mclk_en;
            s[k]  = i2s_sclk_en;
            em[k] = (k != 0) && (k % 4 == 0);
            es[k] = (k == 16);
            if (k < 16) step(1);
        end
        chk("mclk_pattern", {47'h0, m}, {47'h0, em});
        chk("sclk_pattern", {47'h0, s}, {47'h0, es});
    endtask

    // Consume the held sample, starve both sources, expect silence after
    // exactly 64 window cycles.
    task automatic do_underrun(input bit stray, input bit clr,
                               input logic [15:0] exp_cnt);
        exp_q.push_back(48'h0);
        pulse_ready();
        step(9);
        i2s_ready = stray;
        step(1);
        i2s_ready = 1'b0;
        step(52);
        chk("window_c63_valid", {63'h0, i2s_valid}, 64'h0);
        step(1);
        chk("window_c64_valid", {63'h0, i2s_valid}, 64'h0);
        underrun_clr = clr;
        step(1);
        underrun_clr = 1'b0;
        chk("underrun_valid", {63'h0, i2s_valid}, 64'h1);
        chk("underrun_data", {16'h0, i2s_data}, 64'h0);
        chk("underrun_cnt", {48'h0, underrun_cnt}, {48'h0, exp_cnt});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok, r0, r1, done, bad_rdy;
        int n;

        rst          = 1'b1;
        cfg_enable   = 1'b0;
        cfg_prio     = 1'b0;
        src0_data    = '0;
        src0_valid   = 1'b0;
        src1_data    = '0;
        src1_valid   = 1'b0;
        i2s_ready    = 1'b0;
        underrun_clr = 1'b0;
        step(2);

        chk("reset_flags",
            {56'h0, busy, i2s_valid, i2s_clk_en, i2s_mclk_en,
             i2s_sclk_en, src0_ready, src1_ready, active_src}, 64'h0);
        chk("reset_data", {16'h0, i2s_data}, 64'h0);
        chk("reset_ucnt", {48'h0, underrun_cnt}, 64'h0);

        // start-up: PRIME takes src0, then phase-aligned strobes
        rst        = 1'b0;
        cfg_enable = 1'b1;
        src0_data  = 48'hAAAAAA555555;
        src0_valid = 1'b1;
        exp_q.push_back(48'hAAAAAA555555);
        wait_run(ok, r0, r1);
        chk("run_entry", {63'h0, ok}, 64'h1);
        chk("prime_grant", {62'h0, r0, r1}, 64'h2);
        chk("prime_hold", {62'h0, i2s_valid, active_src}, 64'h2);
        check_strobes();

        // priority arbitration
        src0_data  = 48'h111111222222;
        src1_data  = 48'h333333444444;
        src1_valid = 1'b1;
        exp_q.push_back(48'h111111222222);
        pulse_ready();
        chk("prio0_ready", {62'h0, src0_ready, src1_ready}, 64'h2);
        step(1);
        chk("prio0_src", {62'h0, i2s_valid, active_src}, 64'h2);

        cfg_prio  = 1'b1;
        src0_data = 48'h0F0F0F0F0F0F;
        src1_data = 48'h123456789ABC;
        exp_q.push_back(48'h123456789ABC);
        pulse_ready();
        chk("prio1_ready", {62'h0, src0_ready, src1_ready}, 64'h1);
        step(1);
        chk("prio1_src", {62'h0, i2s_valid, active_src}, 64'h3);

        // fallback to the non-priority source
        cfg_prio   = 1'b0;
        src0_valid = 1'b0;
        src1_data  = 48'h555555666666;
        exp_q.push_back(48'h555555666666);
        pulse_ready();
        chk("fallback_ready", {62'h0, src0_ready, src1_ready}, 64'h1);
        step(1);
        chk("fallback_src", {62'h0, i2s_valid, active_src}, 64'h3);

        // underruns: count, saturation, clear-vs-increment
        src1_valid = 1'b0;
        do_underrun(1'b1, 1'b0, 16'h0001);
        force dut.underrun_cnt = 16'hFFFF;
        step(1);
        release dut.underrun_cnt;
        do_underrun(1'b0, 1'b0, 16'hFFFF);
        do_underrun(1'b0, 1'b1, 16'h0000);

        // drain: no refill, exactly 128 sclk strobes after last consume
        src0_data  = 48'hDEADBEEFCAFE;
        src0_valid = 1'b1;
        cfg_enable = 1'b0;
        step(1);
        chk("drain_busy", {63'h0, busy}, 64'h1);
        pulse_ready();
        n       = 0;
        done    = 1'b0;
        bad_rdy = 1'b0;
        for (int i = 0; i < 128 * 16 + 64; i++) begin
            if (i2s_sclk_en) n++;
            if (n == 64) cfg_enable = 1'b1;
            bad_rdy |= src0_ready | src1_ready;
            step(1);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        cfg_enable = 1'b0;
        src0_valid = 1'b0;
        chk("drain_done", {63'h0, done}, 64'h1);
        chk("drain_strobes", 64'(n), 64'd128);
        chk("drain_no_ready", {63'h0, bad_rdy}, 64'h0);
        chk("idle_outputs",
            {60'h0, i2s_clk_en, i2s_mclk_en, i2s_sclk_en, i2s_valid}, 64'h0);
        step(2);
        chk("idle_stays", {63'h0, busy}, 64'h0);

        // restart from src1: strobes must re-align
        src1_data  = 48'hABCDEF012345;
        src1_valid = 1'b1;
        cfg_enable = 1'b1;
        exp_q.push_back(48'hABCDEF012345);
        wait_run(ok, r0, r1);
        chk("run_entry2", {63'h0, ok}, 64'h1);
        chk("restart_grant", {62'h0, r0, r1}, 64'h1);
        chk("restart_hold", {62'h0, i2s_valid, active_src}, 64'h3);
        check_strobes();
        src1_valid = 1'b0;
        do_underrun(1'b0, 1'b0, 16'h0001);

        // reset in RUN
        rst = 1'b1;
        exp_q.delete();
        step(1);
        chk("midrst_flags",
            {56'h0, busy, i2s_valid, i2s_clk_en, i2s_mclk_en,
             i2s_sclk_en, src0_ready, src1_ready, active_src}, 64'h0);
        chk("midrst_data", {16'h0, i2s_data}, 64'h0);
        chk("midrst_ucnt", {48'h0, underrun_cnt}, 64'h0);
        cfg_enable = 1'b0;
        rst        = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
